segment_shift_driver: RTL and testbench

- Scans an 8-digit 7-segment display through two daisy-free 74HC595-style shift registers: one for the segment pattern, one for the digit (common) select.
- Holds a write-addressable digit buffer fed by the CPU bus.
- Generates the seg_*/com_* serial, shift-clock, latch and output-enable signals that the board top routes straight to pins.

---
 rtl/segment_shift_driver.sv | 160 ++++++++++++++++
 tb/tb_segment_shift_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/segment_shift_driver.sv
// Scans an 8-digit 7-segment display through two 74HC595-style chains (segments, digit select).
// Optional macro SEG_DRIVER_BRIGHTNESS_EN adds a 4-bit brightness input that trims on-time during HOLD.
module segment_shift_driver #(
  parameter int DIGITS         = 8,
  parameter int CLK_DIV        = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int COM_ACTIVE_LOW = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       blank,
`ifdef SEG_DRIVER_BRIGHTNESS_EN
  input  logic [3:0] brightness,
`endif
  output logic       seg_ser,
  output logic       seg_srclk,
  output logic       seg_rclk,
  output logic       seg_oe,
  output logic       com_ser,
  output logic       com_srclk,
  output logic       com_rclk,
  output logic       com_oe,
  output logic       frame_done
);

  localparam int TMAX = (CLK_DIV > HOLD_CYCLES) ? CLK_DIV : HOLD_CYCLES;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    LAST_DIGIT = 3'(DIGITS - 1);

  localparam logic [2:0] S_LOAD     = 3'd0;
  localparam logic [2:0] S_SHIFT_LO = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_LATCH    = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;

  typedef struct packed {
    logic       en;
    logic [2:0] addr;
    logic [7:0] data;
  } wr_req_t;

  wr_req_t                  wreq;
  logic [DIGITS-1:0][7:0]   dbuf;
  logic [2:0]               state, state_nx;
  logic [CW-1:0]            tick;
  logic                     phase_last;
  logic [2:0]               bit_cnt;
  logic [2:0]               digit;
  logic [7:0]               seg_sh, com_sh;
  logic [7:0]               com_pat;
  logic                     srclk_q, rclk_q;
  logic                     started;
  logic                     dim;

  assign wreq = '{en: wr_en, addr: wr_addr, data: wr_data};

  // Addresses at or beyond DIGITS match no entry, so such writes fall away.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dbuf <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++)
        if (wreq.en && wreq.addr == 3'(i)) dbuf[i] <= wreq.data;
    end
  end

  assign com_pat = (COM_ACTIVE_LOW != 0) ? ~(8'h01 << digit) : (8'h01 << digit);

  always_comb begin
    case (state)
      S_LOAD:  phase_last = 1'b1;
      S_HOLD:  phase_last = (tick == HOLD_LAST);
      default: phase_last = (tick == DIV_LAST);
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:     state_nx = S_SHIFT_LO;
      S_SHIFT_LO: if (phase_last) state_nx = S_SHIFT_HI;
      S_SHIFT_HI: if (phase_last) state_nx = (bit_cnt == 3'd0) ? S_LATCH : S_SHIFT_LO;
      S_LATCH:    if (phase_last) state_nx = S_HOLD;
      S_HOLD:     if (phase_last) state_nx = S_LOAD;
      default:    state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_LOAD;
      tick    <= '0;
      bit_cnt <= 3'd7;
      digit   <= 3'd0;
      seg_sh  <= 8'h00;
      com_sh  <= 8'h00;
      started <= 1'b0;
    end else begin
      state <= state_nx;
      tick  <= phase_last ? '0 : tick + 1'b1;
      case (state)
        S_LOAD: begin
          seg_sh  <= dbuf[digit];
          com_sh  <= com_pat;
          bit_cnt <= 3'd7;
        end
        S_SHIFT_HI: if (phase_last) begin
          seg_sh  <= {seg_sh[6:0], 1'b0};
          com_sh  <= {com_sh[6:0], 1'b0};
          bit_cnt <= bit_cnt - 3'd1;
        end
        S_LATCH: if (phase_last) started <= 1'b1;
        S_HOLD:  if (phase_last) digit <= (digit == LAST_DIGIT) ? 3'd0 : digit + 3'd1;
        default: ;
      endcase
    end
  end

  // srclk/rclk come straight from flops fed by the next state so the pins never glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
    end else begin
      srclk_q <= (state_nx == S_SHIFT_HI);
      rclk_q  <= (state_nx == S_LATCH);
    end
  end

`ifdef SEG_DRIVER_BRIGHTNESS_EN
  logic [11:0] bright_prod, bright_lim;
  assign bright_prod = 12'(brightness) * 12'(HOLD_CYCLES);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             bright_lim <= '0;
    else if (state == S_LATCH && phase_last) bright_lim <= bright_prod >> 4;
  end

  // Lit only for the leading part of HOLD; dark everywhere else.
  assign dim = !((state == S_HOLD) && (12'(tick) < bright_lim));
`else
  assign dim = 1'b0;
`endif

  assign seg_ser    = seg_sh[7];
  assign com_ser    = com_sh[7];
  assign seg_srclk  = srclk_q;
  assign com_srclk  = srclk_q;
  assign seg_rclk   = rclk_q;
  assign com_rclk   = rclk_q;
  assign seg_oe     = ~started | rclk_q | blank | dim;
  assign com_oe     = ~started | rclk_q | blank | dim;
  assign frame_done = (state == S_LATCH) && phase_last && (digit == LAST_DIGIT);

endmodule

// File: tb/tb_segment_shift_driver.sv
// Scoreboard bench: stimulus pushes expected latched bytes, a negedge monitor decodes the chains.
module tb_segment_shift_driver;
  localparam int DIGITS       = 8;
  localparam int CLK_DIV      = 2;
  localparam int HOLD_CYCLES  = 16;
  localparam int DIGIT_PERIOD = 51;
  localparam int FRAME_PERIOD = 408;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic blank = 1'b0;
`ifdef SEG_DRIVER_BRIGHTNESS_EN
  logic [3:0] brightness = 4'd8;
`endif
  logic seg_ser, seg_srclk, seg_rclk, seg_oe;
  logic com_ser, com_srclk, com_rclk, com_oe;
  logic frame_done;

  segment_shift_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .HOLD_CYCLES(HOLD_CYCLES),
                         .COM_ACTIVE_LOW(1)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .blank(blank),
`ifdef SEG_DRIVER_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .seg_ser(seg_ser), .seg_srclk(seg_srclk), .seg_rclk(seg_rclk), .seg_oe(seg_oe),
    .com_ser(com_ser), .com_srclk(com_srclk), .com_rclk(com_rclk), .com_oe(com_oe),
    .frame_done(frame_done));

  always #5 clock = ~clock;

  typedef struct { logic [7:0] seg; logic [7:0] com; } exp_t;
  exp_t exp_q[$];
  logic [7:0] mbuf [DIGITS];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic push_frame();
    exp_t e;
    for (int d = 0; d < DIGITS; d++) begin
      e.seg = mbuf[d];
      e.com = ~(8'h01 << d);
      exp_q.push_back(e);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    mbuf[a] = d;
  endtask

  task automatic wait_fd();
    for (int t = 0; t < 1000; t++) begin
      step(1);
      if (frame_done) break;
    end
    chk("frame_done_timeout", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ser"},   {30'd0, seg_ser, com_ser},     32'd0);
    chk({tag, "_srclk"}, {30'd0, seg_srclk, com_srclk}, 32'd0);
    chk({tag, "_rclk"},  {30'd0, seg_rclk, com_rclk},   32'd0);
    chk({tag, "_oe"},    {30'd0, seg_oe, com_oe},       32'd3);
    chk({tag, "_fd"},    {31'd0, frame_done},           32'd0);
  endtask

  // Monitor state
  int cyc = 0, bits = 0, hi_w = 0, lo_w = 0, hidx = 1000, blim = HOLD_CYCLES;
  int t_rclk = -1, t_fd = -1;
  logic p_srclk = 0, p_rclk = 0, p_fd = 0, started = 0, exp_oe;
  logic [7:0] sacc = 0, cacc = 0;

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      bits = 0; started = 0; hidx = 1000; t_rclk = -1; t_fd = -1;
      p_srclk = 0; p_rclk = 0; p_fd = 0; hi_w = 0; lo_w = 0;
    end else begin
      chk("lockstep", {30'd0, com_srclk, com_rclk}, {30'd0, seg_srclk, seg_rclk});
      if (seg_srclk && !p_srclk) begin
        if (bits > 0) chk("srclk_low_width", lo_w, CLK_DIV);
        sacc = {sacc[6:0], seg_ser};
        cacc = {cacc[6:0], com_ser};
        bits++; hi_w = 1;
      end else if (seg_srclk) hi_w++;
      if (!seg_srclk && p_srclk) begin
        chk("srclk_high_width", hi_w, CLK_DIV);
        lo_w = 1;
      end else if (!seg_srclk) lo_w++;
      if (seg_rclk && !p_rclk) begin
        chk("bits_per_digit", bits, 8);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL scoreboard_empty: latched seg %0h com %0h, expected no latch", sacc, cacc);
        end else begin
          e = exp_q.pop_front();
          chk("seg_byte", {24'd0, sacc}, {24'd0, e.seg});
          chk("com_byte", {24'd0, cacc}, {24'd0, e.com});
        end
        bits = 0;
        if (t_rclk >= 0) chk("rclk_spacing", cyc - t_rclk, DIGIT_PERIOD);
        t_rclk = cyc;
      end
      if (!seg_rclk && p_rclk) begin
        started = 1; hidx = 0;
`ifdef SEG_DRIVER_BRIGHTNESS_EN
        blim = (int'(brightness) * HOLD_CYCLES) >> 4;
`endif
      end else hidx++;
`ifdef SEG_DRIVER_BRIGHTNESS_EN
      exp_oe = !started || seg_rclk || !(hidx < HOLD_CYCLES && hidx < blim) || blank;
`else
      exp_oe = !started || seg_rclk || blank;
`endif
      chk("seg_oe", {31'd0, seg_oe}, {31'd0, exp_oe});
      chk("com_oe", {31'd0, com_oe}, {31'd0, exp_oe});
      if (frame_done) begin
        chk("frame_done_width", {31'd0, p_fd}, 32'd0);
        chk("frame_done_in_latch", {31'd0, seg_rclk}, 32'd1);
        if (t_fd >= 0) chk("frame_spacing", cyc - t_fd, FRAME_PERIOD);
        t_fd = cyc;
      end
      p_srclk = seg_srclk; p_rclk = seg_rclk; p_fd = frame_done;
    end
  end

  initial begin
    for (int d = 0; d < DIGITS; d++) mbuf[d] = 8'h00;
    step(3);
    chk_reset_outputs("reset");
    push_frame();
    // Release coincides with the first LOAD: digit 0 still loads the old zero.
    reset = 1'b0;
    wr(3'd0, 8'h3F);
    step(1);
    wr_en = 1'b0;

    wait_fd();                       // frame 0 done, now in last LATCH
    wr(3'd1, 8'h06); step(1);
    wr(3'd7, 8'h80); step(1);
    wr_en = 1'b0;
    push_frame();                    // frame 1: 3F 06 00 00 00 00 00 80
    step(183);                       // digit 3, SHIFT_HI of bit 4
    wr(3'd3, 8'hFF); step(1);
    wr_en = 1'b0;

    wait_fd();                       // frame 1 done
    push_frame();                    // frame 2 shows FF on digit 3
    blank = 1'b1;

    wait_fd();                       // frame 2 done
    blank = 1'b0;
`ifdef SEG_DRIVER_BRIGHTNESS_EN
    brightness = 4'd0;
`endif
    push_frame();
    step(275);                       // digit 5, first SHIFT_HI cycle
    reset = 1'b1;
    #1;
    chk_reset_outputs("midop_reset");
    exp_q.delete();
    for (int d = 0; d < DIGITS; d++) mbuf[d] = 8'h00;
    push_frame();
    step(3);
    reset = 1'b0;

    wait_fd();
    step(5);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
